// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the display blocks.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_UP    = 7'b1011100;
  localparam logic [6:0] SEG_DOWN  = 7'b1100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg7_digit_decoder.sv
// Combinational decimal digit to active-low 7-segment decoder.
// Codes above 9 decode to a dark digit.
module seg7_digit_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit < 4'd10) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/ping_pong_seg7_scanner.sv
// Time-multiplexed 4-digit display of the ping-pong counter: tens, ones and two
// direction arrows, all taken from one snapshot per frame so digits never tear.
module ping_pong_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 131072,
  parameter bit          BLANK_LEADING = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       display_en,
  input  logic [3:0] value,
  input  logic       direction,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    snap_val_q;
  logic          snap_dir_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic          tens;
  logic [3:0]    ones;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;

  assign tick = (presc_q == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= 2'd0;
      snap_val_q <= 4'd0;
      snap_dir_q <= 1'b1;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        idx_q <= idx_q + 2'd1;
        // Frame wrap: the only point where the counter inputs are sampled.
        if (idx_q == 2'd3) begin
          snap_val_q <= value;
          snap_dir_q <= direction;
        end
      end
    end
  end

  // Single compare/subtract is enough BCD for a 0..15 range.
  assign tens  = (snap_val_q >= 4'd10);
  assign ones  = tens ? (snap_val_q - 4'd10) : snap_val_q;
  assign digit = (idx_q == 2'd0) ? {3'b000, tens} : ones;

  seg7_digit_decoder u_digit_decoder (
    .digit (digit),
    .seg   (digit_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (display_en) begin
      unique case (idx_q)
        2'd0: begin
          if (!(BLANK_LEADING && !tens)) begin
            an_d  = 4'b0111;
            seg_d = digit_seg;
          end
        end
        2'd1: begin
          an_d  = 4'b1011;
          seg_d = digit_seg;
        end
        2'd2: begin
          an_d  = 4'b1101;
          seg_d = snap_dir_q ? SEG_UP : SEG_DOWN;
        end
        default: begin
          an_d  = 4'b1110;
          seg_d = snap_dir_q ? SEG_UP : SEG_DOWN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_ping_pong_seg7_scanner.sv
// Scoreboard bench: a cycle-level reference model pushes expected display words,
// a negedge monitor pops and compares them against two DUTs (leading zero on/off).
module tb_ping_pong_seg7_scanner;

  localparam int R = 4;

  logic       clk;
  logic       rst_n;
  logic       display_en;
  logic [3:0] value;
  logic       direction;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;

  ping_pong_seg7_scanner #(.REFRESH_DIV(R), .BLANK_LEADING(1'b0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .display_en (display_en),
    .value      (value),
    .direction  (direction),
    .an         (an0),
    .seg        (seg0),
    .dp         (dp0)
  );

  ping_pong_seg7_scanner #(.REFRESH_DIV(R), .BLANK_LEADING(1'b1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .display_en (display_en),
    .value      (value),
    .direction  (direction),
    .an         (an1),
    .seg        (seg1),
    .dp         (dp1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] an0;
    logic [6:0] seg0;
    logic [3:0] an1;
    logic [6:0] seg1;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
  endtask

  function automatic logic [6:0] gold(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // What the display shows in slot s for a snapshot (v, d).
  function automatic void model_slot(input int s, input int v, input bit d, input bit en,
                                     input bit bl, output logic [3:0] a, output logic [6:0] g);
    a = 4'b1111;
    g = 7'b1111111;
    if (!en) return;
    if (s == 0 && bl && v < 10) return;
    a = ~(4'b1000 >> s);
    if (s == 0)      g = gold(v / 10);
    else if (s == 1) g = gold(v % 10);
    else             g = d ? 7'b1011100 : 7'b1100011;
  endfunction

  // Reference model: n counts clocks since reset release.
  int n  = 0;
  int mv = 0;
  bit md = 1'b1;

  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n  = 0;
      mv = 0;
      md = 1'b1;
      e.an0 = 4'b1111; e.seg0 = 7'b1111111;
      e.an1 = 4'b1111; e.seg1 = 7'b1111111;
    end else begin
      model_slot((n / R) % 4, mv, md, display_en, 1'b0, e.an0, e.seg0);
      model_slot((n / R) % 4, mv, md, display_en, 1'b1, e.an1, e.seg1);
      if (n % (4 * R) == 4 * R - 1) begin
        mv = int'(value);
        md = direction;
      end
      n++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an_lead0",  {28'd0, an0},  {28'd0, e.an0});
      check("seg_lead0", {25'd0, seg0}, {25'd0, e.seg0});
      check("an_blank",  {28'd0, an1},  {28'd0, e.an1});
      check("seg_blank", {25'd0, seg1}, {25'd0, e.seg1});
      check("dp",        {31'd0, dp0 & dp1}, 32'd1);
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    display_en = 1'b1;
    value      = 4'd0;
    direction  = 1'b1;
    run(3);
    rst_n = 1'b1;
    value = 4'd13;
    run(37);

    // Asynchronous reset between edges must clear outputs with no clock.
    #2 rst_n = 1'b0;
    #1;
    check("rst_an",  {28'd0, an0},  32'hf);
    check("rst_seg", {25'd0, seg0}, 32'h7f);
    check("rst_dp",  {31'd0, dp0},  32'd1);
    check("rst_an_b", {28'd0, an1}, 32'hf);
    @(negedge clk);
    rst_n = 1'b1;

    value = 4'd13;
    direction = 1'b1;
    run(38);          // lands mid slot 1 of a frame
    value = 4'd6;
    run(30);
    direction = 1'b0;
    run(36);
    display_en = 1'b0;
    run(10);
    display_en = 1'b1;
    run(20);
    value = 4'd7;
    run(36);
    value = 4'd15;
    direction = 1'b1;
    run(36);

    for (int v = 0; v < 16; v++) begin
      for (int d = 0; d < 2; d++) begin
        value     = 4'(v);
        direction = d[0];
        run(4 * R + 3);
      end
    end

    for (int i = 0; i < 80; i++) begin
      value      = 4'($urandom_range(0, 15));
      direction  = 1'($urandom);
      display_en = ($urandom_range(0, 7) != 0);
      run($urandom_range(1, 20));
    end
    display_en = 1'b1;
    run(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
